// File: rtl/prm_regarb_pkg.sv
// prm_regarb_pkg
// Shared definitions for the register-file write arbiter:
//   - default WIDTH/DEPTH/AW/NREQ parameter set
//   - rr_pick(): round-robin winner selection over up to MAX_NREQ requesters
// Optional build macro used by the arbiter top: PRM_REGARB_STAT_EN.
package prm_regarb_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_DEPTH = 4;
  localparam int DEF_AW    = 2;
  localparam int DEF_NREQ  = 4;
  localparam int MAX_NREQ  = 8;

  typedef struct packed {
    logic       found;
    logic [2:0] idx;
  } rr_pick_t;

  // Scan last+1, last+2, ... (mod nreq) and return the first eligible index.
  // Bits of elig at or above nreq are ignored.
  function automatic rr_pick_t rr_pick(input logic [MAX_NREQ-1:0] elig,
                                       input logic [2:0]          last,
                                       input int                  nreq);
    rr_pick_t res;
    int       cand;
    res = '0;
    for (int k = 1; k <= MAX_NREQ; k++) begin
      cand = (int'(last) + k) % nreq;
      if ((k <= nreq) && !res.found && elig[cand[2:0]]) begin
        res.found = 1'b1;
        res.idx   = cand[2:0];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/prm_register_ce.sv
// prm_register_ce
// One enable-gated storage register of the shared register file.
// Ports:
//   clk   - system clock
//   rst_n - asynchronous active-low reset, clears q
//   we    - write enable; d is captured on the rising edge when high
//   d     - write data
//   q     - stored value
module prm_register_ce #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (we) begin
      q <= d;
    end
  end

endmodule

// File: rtl/prm_regfile_wr_arbiter.sv
// prm_regfile_wr_arbiter
// Shares a DEPTH-entry register file between NREQ write requesters with
// round-robin arbitration; at most one write is granted per clock.
// Ports:
//   clk          - system clock
//   rst_n        - asynchronous active-low reset
//   req          - per-requester write request (level, held until granted)
//   waddr        - packed write addresses, requester i at [i*AW +: AW]
//   wdata        - packed write data, requester i at [i*WIDTH +: WIDTH]
//   gnt          - registered one-hot grant pulse
//   raddr        - read address
//   rdata        - combinational read of register raddr
//   busy         - registered; a request was left pending on the last edge
//   conflict_cnt - (only with PRM_REGARB_STAT_EN) saturating count of edges
//                  where two or more requesters were eligible
module prm_regfile_wr_arbiter
  import prm_regarb_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH,
  parameter int AW    = DEF_AW,
  parameter int NREQ  = DEF_NREQ
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*AW-1:0]    waddr,
  input  logic [NREQ*WIDTH-1:0] wdata,
  output logic [NREQ-1:0]       gnt,
  input  logic [AW-1:0]         raddr,
  output logic [WIDTH-1:0]      rdata,
  output logic                  busy
`ifdef PRM_REGARB_STAT_EN
  ,
  output logic [15:0]           conflict_cnt
`endif
);

  logic [NREQ-1:0]     elig;
  logic [MAX_NREQ-1:0] elig_ext;
  rr_pick_t            pick;
  logic [NREQ-1:0]     win_onehot;
  logic [AW-1:0]       win_addr;
  logic [WIDTH-1:0]    win_data;
  logic [2:0]          last;
  logic [WIDTH-1:0]    regs [DEPTH];

  // A requester granted on the previous edge sits out one cycle so it can
  // drop req without being granted twice.
  assign elig = req & ~gnt;

  always_comb begin
    elig_ext             = '0;
    elig_ext[NREQ-1:0]   = elig;
    pick                 = rr_pick(elig_ext, last, NREQ);
    win_onehot           = '0;
    win_addr             = '0;
    win_data             = '0;
    // Loop-based mux keeps index widths matched for any NREQ.
    for (int i = 0; i < NREQ; i++) begin
      if (pick.found && (pick.idx == 3'(i))) begin
        win_onehot[i] = 1'b1;
        win_addr      = waddr[i*AW +: AW];
        win_data      = wdata[i*WIDTH +: WIDTH];
      end
    end
  end

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_reg
      logic we;
      assign we = pick.found && (win_addr == AW'(gi));
      prm_register_ce #(.WIDTH(WIDTH)) u_reg (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (we),
        .d     (win_data),
        .q     (regs[gi])
      );
    end
  endgenerate

  // No bypass: a write becomes visible the cycle gnt is high.
  assign rdata = regs[raddr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt  <= '0;
      busy <= 1'b0;
      last <= 3'(NREQ - 1);  // requester 0 scans first after reset
    end else begin
      gnt  <= win_onehot;
      busy <= |(elig & ~win_onehot);
      if (pick.found) begin
        last <= pick.idx;
      end
    end
  end

`ifdef PRM_REGARB_STAT_EN
  logic multi_elig;
  // Clearing the lowest set bit leaves something only if two or more are set.
  assign multi_elig = |(elig & (elig - NREQ'(1)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      conflict_cnt <= '0;
    end else if (multi_elig && (conflict_cnt != 16'hFFFF)) begin
      conflict_cnt <= conflict_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_prm_regfile_wr_arbiter.sv
// tb_prm_regfile_wr_arbiter
// Directed bench for prm_regfile_wr_arbiter (WIDTH=8, DEPTH=4, NREQ=4).
// Expected grants are queued when requests are driven and popped when the
// design shows a grant. Build with PRM_REGARB_STAT_EN to also cover
// conflict_cnt.
module tb_prm_regfile_wr_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  req;
  logic [7:0]  waddr;
  logic [31:0] wdata;
  logic [3:0]  gnt;
  logic [1:0]  raddr;
  logic [7:0]  rdata;
  logic        busy;
`ifdef PRM_REGARB_STAT_EN
  logic [15:0] conflict_cnt;
`endif

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [3:0] g;
    logic [1:0] a;
    logic [7:0] d;
  } exp_t;
  exp_t sb[$];

  prm_regfile_wr_arbiter #(
    .WIDTH(8), .DEPTH(4), .AW(2), .NREQ(4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (req),
    .waddr (waddr),
    .wdata (wdata),
    .gnt   (gnt),
    .raddr (raddr),
    .rdata (rdata),
    .busy  (busy)
`ifdef PRM_REGARB_STAT_EN
    ,
    .conflict_cnt (conflict_cnt)
`endif
  );

  initial forever #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic set_req(input int i, input logic [1:0] a, input logic [7:0] d);
    waddr[i*2 +: 2] = a;
    wdata[i*8 +: 8] = d;
  endtask

  task automatic push_exp(input logic [3:0] g, input logic [1:0] a, input logic [7:0] d);
    exp_t e;
    e.g = g;
    e.a = a;
    e.d = d;
    sb.push_back(e);
  endtask

  // Next cycle must carry the oldest expected grant, with its data readable.
  task automatic next_gnt();
    exp_t e;
    @(negedge clk);
    if (sb.size() == 0) begin
      chk("sb_underflow", 32'(sb.size()), 32'd1);
    end else begin
      e = sb.pop_front();
      chk("gnt", 32'(gnt), 32'(e.g));
      raddr = e.a;
      #1;
      chk("gnt_rdata", 32'(rdata), 32'(e.d));
      $display("txn gnt=%b addr=%0d data=%02h busy=%b", gnt, e.a, rdata, busy);
    end
  endtask

  task automatic no_gnt(input string tag);
    @(negedge clk);
    chk(tag, 32'(gnt), 32'd0);
  endtask

  task automatic chk_regs(input string tag, input logic [31:0] vals);
    for (int i = 0; i < 4; i++) begin
      raddr = 2'(i);
      #1;
      chk($sformatf("%s_reg%0d", tag, i), 32'(rdata), 32'(vals[i*8 +: 8]));
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    req   = '0;
    waddr = '0;
    wdata = '0;
    raddr = '0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Reset state and idle
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk_regs("rst", 32'h0);
    for (int i = 0; i < 10; i++) no_gnt("idle_gnt");
    chk("idle_busy", 32'(busy), 32'd0);
    chk_regs("idle", 32'h0);

    // Single requester, req held through the grant cycle
    set_req(2, 2'd3, 8'hA5);
    req = 4'b0100;
    push_exp(4'b0100, 2'd3, 8'hA5);
    next_gnt();
    no_gnt("hold_mask");
    chk("hold_busy", 32'(busy), 32'd0);
    push_exp(4'b0100, 2'd3, 8'hA5);
    next_gnt();
    req = 4'b0000;
    no_gnt("single_drop");

    // All four requesting continuously: 0,1,2,3,0
    do_reset();
    for (int i = 0; i < 4; i++) set_req(i, 2'(i), 8'(8'h10 + i));
    req = 4'b1111;
    for (int k = 0; k < 5; k++) push_exp(4'(1 << (k % 4)), 2'(k % 4), 8'(8'h10 + (k % 4)));
    for (int k = 0; k < 5; k++) begin
      next_gnt();
      chk("rr_busy", 32'(busy), 32'd1);
    end
    req = 4'b0000;
    no_gnt("rr_drop");
    chk("rr_idle_busy", 32'(busy), 32'd0);
    chk_regs("rr", 32'h13121110);

    // Two requesters, same address
    do_reset();
    set_req(0, 2'd2, 8'h11);
    set_req(1, 2'd2, 8'h22);
    req = 4'b0011;
    push_exp(4'b0001, 2'd2, 8'h11);
    push_exp(4'b0010, 2'd2, 8'h22);
    next_gnt();
    req = 4'b0010;
    next_gnt();
    req = 4'b0000;
    no_gnt("same_drop");
    chk_regs("same", 32'h00220000);

    // Reset lands in the cycle after req[1] asserts
    set_req(1, 2'd1, 8'h5A);
    req = 4'b0010;
    @(negedge clk);
    chk("pre_rst_gnt", 32'(gnt), 32'b0010);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_gnt", 32'(gnt), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk_regs("mid_rst", 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    push_exp(4'b0010, 2'd1, 8'h5A);
    next_gnt();
    req = 4'b0000;
    no_gnt("mid_drop");

    // Reset with requesters 0 and 1 pending: 0 goes first
    @(negedge clk);
    rst_n = 1'b0;
    set_req(0, 2'd0, 8'h77);
    req = 4'b0011;
    @(negedge clk);
    rst_n = 1'b1;
    push_exp(4'b0001, 2'd0, 8'h77);
    push_exp(4'b0010, 2'd1, 8'h5A);
    next_gnt();
    req = 4'b0010;
    next_gnt();
    req = 4'b0000;
    no_gnt("prio_drop");
    chk_regs("prio", 32'h00005A77);

`ifdef PRM_REGARB_STAT_EN
    do_reset();
    chk("cnt_rst", 32'(conflict_cnt), 32'd0);
    for (int i = 0; i < 3; i++) set_req(i, 2'(i), 8'(8'h40 + i));
    req = 4'b0111;
    repeat (5) @(negedge clk);
    req = 4'b0000;
    chk("cnt_5", 32'(conflict_cnt), 32'd5);
    @(negedge clk);
    chk("cnt_hold", 32'(conflict_cnt), 32'd5);
    req = 4'b1111;
    repeat (70000) @(negedge clk);
    req = 4'b0000;
    @(negedge clk);
    chk("cnt_sat", 32'(conflict_cnt), 32'hFFFF);
`endif

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/prm_regfile_wr_arbiter.md
Name: prm_regfile_wr_arbiter

Overview:
- Shares one small register file between NREQ write requesters using round-robin arbitration.
- The register file is built from DEPTH enable-gated registers.
- Grants at most one write per clock.
- Provides one combinational read port for the consumer side of the datapath.

Parameters:
- WIDTH, 8: data width of each register.
- DEPTH, 4: number of registers; must be a power of two, at least 2.
- AW, 2: address width; must equal log2(DEPTH).
- NREQ, 4: number of write requesters, 2..8.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset; asynchronous, active-low.
- req  in  NREQ  write request per requester; level, held until granted.
- waddr  in  NREQ*AW  packed write addresses; requester i at bits [i*AW +: AW].
- wdata  in  NREQ*WIDTH  packed write data; requester i at bits [i*WIDTH +: WIDTH].
- gnt  out  NREQ  registered one-hot grant pulse.
- raddr  in  AW  read address.
- rdata  out  WIDTH  combinational read of register raddr.
- busy  out  1  registered; 1 when any request was pending but not granted on the last edge.

Behaviour:
- Reset (async, rst_n=0):
  - all registers 0
  - gnt=0, busy=0
  - round-robin pointer last=NREQ-1, so requester 0 has first priority
  - reset mid-transaction discards the in-flight grant; requesters keep req high and are re-arbitrated after release.
- Eligibility:
  - elig[i] = req[i] & ~gnt[i].
  - A requester granted on the previous edge is masked for one cycle, so it can drop req without being granted twice.
  - Consequence: a single requester gets at most one write every 2 cycles.
- Selection: combinational. The winner is the first eligible index scanning last+1, last+2, ... modulo NREQ.
- On each rising edge with any elig bit set:
  - register[waddr[winner]] <= wdata[winner] (write enable for that register only)
  - gnt <= one-hot(winner)
  - last <= winner.
- With no elig bit set: gnt <= 0, last unchanged, no register written.
- Write latency: data is visible on rdata in the cycle gnt is high, when raddr matches; 1 edge after selection.
- Requester rule: keep req/waddr/wdata stable until its gnt is seen high; drop or change them in the gnt cycle.
- Dropping req before grant is permitted; it simply withdraws the request.
- Simultaneous requests to the same address: serialized by round-robin; the last grant wins the final value.
- busy <= |(elig & ~onehot(winner)) on each edge; 0 when there are no requests.
- rdata = register[raddr], purely combinational, no bypass of the write in progress.
- Pointer wrap: after winner NREQ-1, the scan starts at 0.

Optional Feature:
- Macro: PRM_REGARB_STAT_EN.
- When defined:
  - Extra output port conflict_cnt, 16 bits.
  - Saturating counter, incremented on each edge where two or more elig bits are set.
  - Holds at 16'hFFFF; reset to 0.
- When undefined: the port and counter are absent; all other behaviour is identical.

Decomposition:
- Package prm_regarb_pkg holds:
  - a default WIDTH/DEPTH/NREQ localparam set
  - the function rr_pick(elig, last) returning the winner index and a found flag.
- Sub-module: one prm_register_ce per register, generated DEPTH times, with we = granted-write & (waddr[winner]==k).
- The arbiter logic stays in this module.

Test Plan (WIDTH=8, DEPTH=4, NREQ=4):
- Reset then idle:
  - rdata=0 for all raddr
  - gnt=0, busy=0
  - no writes for 10 cycles.
- Single requester:
  - req[2]=1, waddr=3, wdata=8'hA5, held until gnt → gnt=4'b0100 one cycle after req; rdata(raddr=3)=8'hA5 in that gnt cycle.
  - Holding req through the gnt cycle yields gnt=0 that cycle, then a re-grant.
- All four requesting continuously, distinct addresses 0..3, data 8'h10..8'h13:
  - grants in order 0,1,2,3,0
  - busy=1 during contention
  - final registers 8'h10..8'h13.
- Same address from req[0] (8'h11) and req[1] (8'h22) at once:
  - gnt 0 then 1
  - register = 8'h22.
- Assert rst_n=0 in the cycle after req[1] asserts:
  - gnt and registers clear immediately
  - after release, with req[1] still high, gnt[1] asserts first
  - pointer = 3, so requester 0 takes priority if also requesting.
- With PRM_REGARB_STAT_EN: 3 requesters held for 5 edges → conflict_cnt increments for every edge with ≥2 eligible; saturation checked by forcing 70000 contention cycles → 16'hFFFF.
